cordic_angle_prep: RTL and testbench
====================================

# cordic_angle_prep

Upstream request stage for the `CORDIC` core.
- Accepts trig requests on a valid/ready handshake and range-reduces integer-degree angles into the core's convergence range of [-90, 90].
- Issues a one-cycle `valid` pulse to the core, waits for `out_valid`, applies quadrant sign correction and returns a tagged result on a valid/ready handshake.
- Only one request is outstanding at a time. A wait timeout ensures a lost core result cannot hang the pipeline.

## Interface
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before an error response.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_angle` in 16: signed integer degrees, full range -32768..32767.
- `req_select` in 4: function code, passed to the core.
- `req_another` in 16: second operand, passed through unchanged.
- `req_tag` in TAG_W: returned with the response.
- `cor_angle` out 16: to core `in_angle`.
- `cor_select` out 4: to core `select`.
- `cor_another` out 16: to core `another`.
- `cor_valid` out 1: to core `valid`; one-cycle pulse.
- `cor_out` in 16: from core `CORDIC_OUT`.
- `cor_out_valid` in 1: from core `out_valid`.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 16: corrected result.
- `rsp_tag` out TAG_W: tag of the request being answered.
- `rsp_folded` out 1: the angle was folded by 180°.
- `rsp_err` out 1: timeout occurred; `rsp_data` = 0.

## Operation
- **Function codes:** SEL_SIN = 4'b0100 and SEL_COS = 4'b1000 are trig codes and are reduced. All other codes bypass reduction: the angle is issued raw and the result is returned raw.
- **States:** IDLE → REDUCE → ISSUE → WAIT → RESP → IDLE. Bypass codes go IDLE → ISSUE.
- **IDLE:** on `req_valid & req_ready`, latch all request fields and `m = |req_angle|` as 16-bit unsigned (32768 is representable).
- **REDUCE:** 7 restoring steps, k = 6 down to 0, one per cycle: if m ≥ 360<<k then m -= 360<<k.
  - After the last step, apply the original sign: r = ±m, giving r in (-360, 360).
- **Wrap to [-180, 180):** r ≥ 180 → r - 360; r < -180 → r + 360.
- **Fold to [-90, 90]:** r > 90 → 180 - r, folded = 1; r < -90 → -180 - r, folded = 1. Otherwise folded = 0. For example, -180 → 0 with folded = 1.
- **ISSUE:** drive `cor_angle`, `cor_select` and `cor_another`; assert `cor_valid` for exactly one cycle; clear the timeout counter.
- **WAIT:** on `cor_out_valid`, capture the result and go to RESP. If the counter reaches TIMEOUT first, go to RESP with `rsp_err` = 1 and `rsp_data` = 0.
- **Correction:** `rsp_data` = -cor_out only when the code is SEL_COS and folded = 1; otherwise `rsp_data` = cor_out. Negating 0x8000 saturates to 0x7FFF.
- **RESP:** `rsp_valid` held with stable data until `rsp_ready`, then go to IDLE.
- `cor_out_valid` outside WAIT is ignored.
- Reset in any state forces IDLE and drops any in-flight transaction. A late `cor_out_valid` after reset is ignored.

## Timing
- All outputs are registered.
- Reset values: `req_ready` 1; all `cor_*` outputs 0; `rsp_valid`, `rsp_data`, `rsp_tag`, `rsp_folded`, `rsp_err` all 0.
- Request accepted at cycle t:
  - trig codes: `cor_valid` high at t+8 (7 REDUCE cycles, then ISSUE);
  - bypass codes: `cor_valid` high at t+1.
- `cor_out_valid` at cycle c → `rsp_valid` high at c+1.
- A response accepted at cycle a → `req_ready` high at a+1.
- Timeout: `rsp_valid` rises TIMEOUT+1 cycles after the `cor_valid` pulse if no result arrives.

## Structure
- Package `cordic_pkg` holds SEL_SIN, SEL_COS, the angle width (16), the fold constants (90, 180, 360) and the state enum.
- One sub-module, `angle_mod360`, contains the iterative 7-step restoring reducer with start/done handshake, the wrap to [-180, 180) and the fold. The top level holds the FSM, the timeout counter, the correction logic and the handshakes.

## Test plan
- angle 0x001E (30°), select 0100 → `cor_angle` 0x001E at t+8; core result 0x4000 → `rsp_data` 0x4000, `rsp_folded` 0.
- angle 0x0096 (150°), select 1000 → `cor_angle` 0x001E, folded = 1; core result 0x6ED9 → `rsp_data` 0x9127.
- angle 0xFE70 (-400°) → `cor_angle` 0xFFD8 (-40). angle 0x8000 (-32768°) → `cor_angle` 0xFFF8 (-8). angle 0x00B4 (180°) → `cor_angle` 0x0000, folded = 1.
- select 0001, angle 0x1234 → `cor_angle` 0x1234 at t+1; result returned unchanged.
- Hold `rsp_ready` low for 5 cycles → `rsp_valid` and `rsp_data` stable and `req_ready` 0 throughout. No core response → `rsp_err` 1, `rsp_data` 0 at TIMEOUT+1 cycles.
- Assert `rst` during WAIT, then pulse `cor_out_valid` → no `rsp_valid`; `req_ready` 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, function codes and FSM encoding for the CORDIC request stage.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int DEG_90  = 90;
    localparam int DEG_180 = 180;
    localparam int DEG_360 = 360;

    localparam logic [3:0] SEL_SIN = 4'b0100;
    localparam logic [3:0] SEL_COS = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic is_trig(input logic [3:0] sel);
        return (sel == SEL_SIN) || (sel == SEL_COS);
    endfunction

endpackage

// File: rtl/angle_mod360.sv
// Iterative angle reducer: 7 restoring subtract steps of 360<<k, then wrap to
// [-180, 180) and fold into [-90, 90]. The last step is resolved combinationally.
module angle_mod360
    import cordic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ANGLE_W-1:0] angle_i,
    output logic               done_o,
    output logic [ANGLE_W-1:0] angle_o,
    output logic               folded_o
);

    localparam logic        [ANGLE_W-1:0] MOD_U = ANGLE_W'(DEG_360);
    localparam logic signed [ANGLE_W-1:0] S90   = ANGLE_W'(DEG_90);
    localparam logic signed [ANGLE_W-1:0] S180  = ANGLE_W'(DEG_180);
    localparam logic signed [ANGLE_W-1:0] S360  = ANGLE_W'(DEG_360);

    logic        [ANGLE_W-1:0] m_q;
    logic        [ANGLE_W-1:0] m_d;
    logic        [ANGLE_W-1:0] step;
    logic                      neg_q;
    logic        [2:0]         k_q;
    logic                      busy_q;
    logic signed [ANGLE_W-1:0] r;
    logic signed [ANGLE_W-1:0] w;
    logic signed [ANGLE_W-1:0] f;
    logic                      fold;

    always_comb begin
        step = MOD_U << k_q;
        m_d  = (m_q >= step) ? (m_q - step) : m_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            k_q    <= 3'd0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            k_q    <= 3'd6;
        end else if (busy_q) begin
            k_q <= k_q - 3'd1;
            if (k_q == 3'd0) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Magnitude fits 16 bits unsigned, so -32768 loads as 32768.
    always_ff @(posedge clk) begin
        if (start_i) begin
            m_q   <= angle_i[ANGLE_W-1] ? (~angle_i + ANGLE_W'(1)) : angle_i;
            neg_q <= angle_i[ANGLE_W-1];
        end else if (busy_q) begin
            m_q <= m_d;
        end
    end

    always_comb begin
        r    = neg_q ? -$signed(m_d) : $signed(m_d);
        w    = r;
        f    = r;
        fold = 1'b0;
        if (r >= S180) begin
            w = r - S360;
        end else if (r < -S180) begin
            w = r + S360;
        end
        f = w;
        if (w > S90) begin
            f    = S180 - w;
            fold = 1'b1;
        end else if (w < -S90) begin
            f    = -S180 - w;
            fold = 1'b1;
        end
    end

    assign done_o   = busy_q && (k_q == 3'd0);
    assign angle_o  = f;
    assign folded_o = fold;

endmodule

// File: rtl/cordic_angle_prep.sv
// Request stage for the CORDIC core: range reduction, single-outstanding issue,
// bounded wait for the core result, cosine sign correction and tagged response.
module cordic_angle_prep
    import cordic_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_angle,
    input  logic [3:0]       req_select,
    input  logic [15:0]      req_another,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      cor_angle,
    output logic [3:0]       cor_select,
    output logic [15:0]      cor_another,
    output logic             cor_valid,
    input  logic [15:0]      cor_out,
    input  logic             cor_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_folded,
    output logic             rsp_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [ANGLE_W-1:0] sat_neg(input logic signed [ANGLE_W-1:0] x);
        if (x == {1'b1, {(ANGLE_W-1){1'b0}}}) begin
            return {1'b0, {(ANGLE_W-1){1'b1}}};
        end
        return ANGLE_W'(-x);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_ready_q;
    logic [15:0]        cor_angle_q;
    logic [3:0]         cor_select_q;
    logic [15:0]        cor_another_q;
    logic               cor_valid_q;
    logic [TAG_W-1:0]   tag_q;
    logic               folded_q;
    logic               rsp_valid_q;
    logic [15:0]        rsp_data_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               rsp_folded_q;
    logic               rsp_err_q;

    logic               accept;
    logic               red_start;
    logic               red_done;
    logic [15:0]        red_angle;
    logic               red_folded;
    logic [15:0]        corrected;

    assign accept    = req_valid & req_ready_q;
    assign red_start = accept & is_trig(req_select);

    angle_mod360 u_mod360 (
        .clk      (clk),
        .rst      (rst),
        .start_i  (red_start),
        .angle_i  (req_angle),
        .done_o   (red_done),
        .angle_o  (red_angle),
        .folded_o (red_folded)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = is_trig(req_select) ? S_REDUCE : S_ISSUE;
            S_REDUCE: if (red_done) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   if (cor_out_valid || (cnt_q == CNT_LAST)) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Only a folded cosine changes sign; folded_q is never set for bypass codes.
    assign corrected = ((cor_select_q == SEL_COS) && folded_q) ? sat_neg(cor_out) : cor_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            cor_angle_q   <= '0;
            cor_select_q  <= '0;
            cor_another_q <= '0;
            cor_valid_q   <= 1'b0;
            tag_q         <= '0;
            folded_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_folded_q  <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == S_IDLE);
            cor_valid_q <= (state_d == S_ISSUE);

            if (state_q == S_IDLE && accept) begin
                cor_select_q  <= req_select;
                cor_another_q <= req_another;
                tag_q         <= req_tag;
                if (!is_trig(req_select)) begin
                    cor_angle_q <= req_angle;
                    folded_q    <= 1'b0;
                end
            end

            if (state_q == S_REDUCE && red_done) begin
                cor_angle_q <= red_angle;
                folded_q    <= red_folded;
            end

            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == S_WAIT && state_d == S_RESP) begin
                rsp_valid_q  <= 1'b1;
                rsp_tag_q    <= tag_q;
                rsp_folded_q <= folded_q;
                rsp_err_q    <= !cor_out_valid;
                rsp_data_q   <= cor_out_valid ? corrected : 16'h0000;
            end else if (state_q == S_RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign cor_angle   = cor_angle_q;
    assign cor_select  = cor_select_q;
    assign cor_another = cor_another_q;
    assign cor_valid   = cor_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_folded  = rsp_folded_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Self-checking bench for cordic_angle_prep: directed vector table, random
// transactions against an arithmetic reference model, timeout and reset cases.
module tb_cordic_angle_prep;

    localparam int TAG_W = 4;
    localparam int TO    = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_angle;
    logic [3:0]       req_select;
    logic [15:0]      req_another;
    logic [TAG_W-1:0] req_tag;
    logic [15:0]      cor_angle;
    logic [3:0]       cor_select;
    logic [15:0]      cor_another;
    logic             cor_valid;
    logic [15:0]      cor_out;
    logic             cor_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_folded;
    logic             rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_angle_prep #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_angle     (req_angle),
        .req_select    (req_select),
        .req_another   (req_another),
        .req_tag       (req_tag),
        .cor_angle     (cor_angle),
        .cor_select    (cor_select),
        .cor_another   (cor_another),
        .cor_valid     (cor_valid),
        .cor_out       (cor_out),
        .cor_out_valid (cor_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_folded    (rsp_folded),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [15:0] angle;
        logic [3:0]  sel;
        logic [15:0] another;
        logic [3:0]  tag;
        logic [15:0] result;
        int          dly;
        int          hold;
        logic [15:0] exp_ang;
        bit          exp_fold;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit trig(input logic [3:0] s);
        return (s == 4'b0100) || (s == 4'b1000);
    endfunction

    // Reference: remainder by 360 with sign of the dividend, wrap, fold.
    task automatic model(input logic [15:0] a, input logic [3:0] s, input logic [15:0] res,
                         output logic [15:0] ang, output bit fold, output logic [15:0] data);
        int r;
        fold = 1'b0;
        if (!trig(s)) begin
            ang = a;
        end else begin
            r = $signed(a) % 360;
            if (r >= 180) r = r - 360;
            else if (r < -180) r = r + 360;
            if (r > 90) begin
                r = 180 - r;
                fold = 1'b1;
            end else if (r < -90) begin
                r = -180 - r;
                fold = 1'b1;
            end
            ang = 16'(r);
        end
        if (s == 4'b1000 && fold) data = (res == 16'h8000) ? 16'h7FFF : 16'(0 - int'(res));
        else data = res;
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [3:0] s, input logic [15:0] an,
                           input logic [3:0] tg, input logic [15:0] res, input bit deliver,
                           input int dly, input int hold, input logic [15:0] e_ang,
                           input bit e_fold, input logic [15:0] e_data, input int e_lat);
        int n;
        bit ok;
        check("req_ready_idle", req_ready, 1);
        req_valid   = 1'b1;
        req_angle   = a;
        req_select  = s;
        req_another = an;
        req_tag     = tg;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!cor_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("issue_latency", n, e_lat);
        check("cor_angle", cor_angle, e_ang);
        check("cor_select", cor_select, s);
        check("cor_another", cor_another, an);
        @(negedge clk);
        check("cor_valid_pulse", cor_valid, 0);
        if (deliver) begin
            repeat (dly) @(negedge clk);
            check("rsp_before_result", rsp_valid, 0);
            cor_out       = res;
            cor_out_valid = 1'b1;
            @(negedge clk);
            cor_out_valid = 1'b0;
            cor_out       = 16'hDEAD;
            check("rsp_valid_rise", rsp_valid, 1);
        end else begin
            n = 1;
            while (!rsp_valid && n < TO + 10) begin
                @(negedge clk);
                n++;
            end
            check("timeout_latency", n, TO + 1);
        end
        check("rsp_data", rsp_data, e_data);
        check("rsp_tag", rsp_tag, tg);
        check("rsp_folded", rsp_folded, e_fold);
        check("rsp_err", rsp_err, !deliver);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== e_data || req_ready !== 1'b0) ok = 1'b0;
            end
            check("hold_stable", ok, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("req_ready_after_rsp", req_ready, 1);
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        bit ok;
        logic [15:0] a, an, res, e_ang, e_data;
        logic [3:0] s, tg;
        bit e_fold;

        vecs[0]  = '{16'h001E, 4'b0100, 16'h1111, 4'h1, 16'h4000, 0, 0, 16'h001E, 0, 16'h4000, 8};
        vecs[1]  = '{16'h0096, 4'b1000, 16'h2222, 4'h2, 16'h6ED9, 1, 0, 16'h001E, 1, 16'h9127, 8};
        vecs[2]  = '{16'hFE70, 4'b0100, 16'h3333, 4'h3, 16'h1234, 2, 0, 16'hFFD8, 0, 16'h1234, 8};
        vecs[3]  = '{16'h8000, 4'b1000, 16'h4444, 4'h4, 16'h7000, 0, 1, 16'hFFF8, 0, 16'h7000, 8};
        vecs[4]  = '{16'h00B4, 4'b1000, 16'h5555, 4'h5, 16'h8000, 3, 0, 16'h0000, 1, 16'h7FFF, 8};
        vecs[5]  = '{16'h1234, 4'b0001, 16'h6666, 4'h6, 16'hABCD, 0, 0, 16'h1234, 0, 16'hABCD, 1};
        vecs[6]  = '{16'h00B4, 4'b0100, 16'h7777, 4'h7, 16'h8000, 1, 0, 16'h0000, 1, 16'h8000, 8};
        vecs[7]  = '{16'h7FFF, 4'b1000, 16'h8888, 4'h8, 16'h0100, 0, 0, 16'h0007, 0, 16'h0100, 8};
        vecs[8]  = '{16'hFF4C, 4'b1000, 16'h9999, 4'h9, 16'h0001, 0, 0, 16'h0000, 1, 16'hFFFF, 8};
        vecs[9]  = '{16'h005A, 4'b0100, 16'hAAAA, 4'hA, 16'h2000, 4, 0, 16'h005A, 0, 16'h2000, 8};
        vecs[10] = '{16'hFFA5, 4'b1000, 16'hBBBB, 4'hB, 16'h0000, 0, 2, 16'hFFA7, 1, 16'h0000, 8};

        rst = 1'b1;
        req_valid = 1'b0;
        req_angle = '0;
        req_select = '0;
        req_another = '0;
        req_tag = '0;
        cor_out = '0;
        cor_out_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_cor", {cor_valid, cor_angle, cor_select, cor_another}, 0);
        check("reset_rsp", {rsp_valid, rsp_data, rsp_tag, rsp_folded, rsp_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].angle, vecs[i].sel, vecs[i].another, vecs[i].tag, vecs[i].result,
                    1'b1, vecs[i].dly, vecs[i].hold, vecs[i].exp_ang, vecs[i].exp_fold,
                    vecs[i].exp_data, vecs[i].exp_lat);
        end

        // Long consumer stall.
        run_txn(16'h001E, 4'b0100, 16'h0F0F, 4'hC, 16'h4000, 1'b1, 0, 5,
                16'h001E, 1'b0, 16'h4000, 8);

        // Lost core result: error response with zero data.
        run_txn(16'h0096, 4'b1000, 16'h0000, 4'hD, 16'h0000, 1'b0, 0, 1,
                16'h001E, 1'b1, 16'h0000, 8);

        // Reset during WAIT, then a late core result must be ignored.
        req_valid   = 1'b1;
        req_angle   = 16'h0042;
        req_select  = 4'b0010;
        req_another = 16'h0;
        req_tag     = 4'hE;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!cor_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rst_case_issue", n, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_case_req_ready", req_ready, 1);
        cor_out       = 16'h5A5A;
        cor_out_valid = 1'b1;
        @(negedge clk);
        cor_out_valid = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        check("rst_case_no_rsp", ok, 1);

        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            an  = 16'($urandom);
            res = 16'($urandom);
            tg  = 4'($urandom);
            case ($urandom_range(0, 2))
                0:       s = 4'b0100;
                1:       s = 4'b1000;
                default: s = 4'($urandom);
            endcase
            if (i % 8 == 0) res = 16'h8000;
            model(a, s, res, e_ang, e_fold, e_data);
            run_txn(a, s, an, tg, res, 1'b1, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), e_ang, e_fold, e_data, trig(s) ? 8 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
